// File: rtl/timer_reg_mc.sv
// timer_reg_mc: NUM_TMR-channel timer with prescaler, register file and IRQ.
// Ports: mclk/h_reset_n; reg_cs/wr/addr/wdata/be -> reg_rdata/reg_ack bus;
//        tmr_tick prescaler pulse, tmr_event per-channel pulse, tmr_irq.
module timer_reg_mc #(
    parameter int NUM_TMR    = 4,
    parameter int TMR_W      = 19,
    parameter int PRESCALE_W = 10,
    parameter int AW         = 4
) (
    input  logic               mclk,
    input  logic               h_reset_n,
    input  logic               reg_cs,
    input  logic               reg_wr,
    input  logic [AW-1:0]      reg_addr,
    input  logic [31:0]        reg_wdata,
    input  logic [3:0]         reg_be,
    output logic [31:0]        reg_rdata,
    output logic               reg_ack,
    output logic               tmr_tick,
    output logic [NUM_TMR-1:0] tmr_event,
    output logic               tmr_irq
);
    localparam logic [1:0] MODE_PER = 2'b01;
    localparam logic [1:0] MODE_UP  = 2'b10;
    localparam logic [TMR_W-1:0]      CNT_ONE = TMR_W'(1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] div_q, div_d, pre_q, pre_d;
    logic                  tick_q, tick_d;
    logic [NUM_TMR-1:0]    stat_q, stat_d, mask_q, mask_d;
    logic [NUM_TMR-1:0]    evt_q, evt_d, en_q, en_d;
    logic [NUM_TMR-1:0]    load_q, load_d, set, clr;
    logic                  irq_q, irq_d, ack_q, ack_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [TMR_W-1:0]      reload_q [NUM_TMR];
    logic [TMR_W-1:0]      reload_d [NUM_TMR];
    logic [TMR_W-1:0]      cnt_q    [NUM_TMR];
    logic [TMR_W-1:0]      cnt_d    [NUM_TMR];
    logic [1:0]            mode_q   [NUM_TMR];
    logic [1:0]            mode_d   [NUM_TMR];

    logic        acc, wr;
    logic [31:0] bm, rd_mux, img, nv_cfg, nv_glbl, nv_mask, nv_clr;
    logic        unused_bits;

    always_comb begin
        acc     = reg_cs & ~ack_q;
        wr      = acc & reg_wr;
        bm      = {{8{reg_be[3]}}, {8{reg_be[2]}},
                   {8{reg_be[1]}}, {8{reg_be[0]}}};
        rd_mux  = '0;
        img     = '0;
        nv_cfg  = '0;
        nv_glbl = (32'(div_q) & ~bm) | (reg_wdata & bm);
        nv_mask = (32'(mask_q) & ~bm) | (reg_wdata & bm);
        nv_clr  = reg_wdata & bm;
        div_d   = div_q;
        mask_d  = mask_q;
        clr     = '0;
        set     = '0;
        en_d    = en_q;
        load_d  = '0;

        if (reg_addr == AW'(0)) rd_mux[PRESCALE_W-1:0] = div_q;
        if (reg_addr == AW'(1)) rd_mux[NUM_TMR-1:0] = stat_q;
        if (reg_addr == AW'(2)) rd_mux[NUM_TMR-1:0] = mask_q;
        if (wr && reg_addr == AW'(0)) div_d = nv_glbl[PRESCALE_W-1:0];
        if (wr && reg_addr == AW'(1)) clr = nv_clr[NUM_TMR-1:0];
        if (wr && reg_addr == AW'(2)) mask_d = nv_mask[NUM_TMR-1:0];

        // Prescaler; a divisor write restarts the count.
        if (pre_q == div_q) begin
            tick_d = 1'b1;
            pre_d  = '0;
        end else begin
            tick_d = 1'b0;
            pre_d  = pre_q + PRE_ONE;
        end
        if (wr && reg_addr == AW'(0)) pre_d = '0;

        for (int i = 0; i < NUM_TMR; i++) begin
            cnt_d[i]    = cnt_q[i];
            reload_d[i] = reload_q[i];
            mode_d[i]   = mode_q[i];
            load_d[i]   = wr && (reg_addr == AW'(4 + 2*i));

            img = '0;
            img[TMR_W-1:0] = reload_q[i];
            img[24]        = en_q[i];
            img[26:25]     = mode_q[i];
            if (reg_addr == AW'(4 + 2*i)) rd_mux = img;
            if (reg_addr == AW'(5 + 2*i)) rd_mux[TMR_W-1:0] = cnt_q[i];

            // Load strobe trails the register capture, masking that tick.
            if (load_q[i]) begin
                cnt_d[i] = (mode_q[i] == MODE_UP) ? '0 : reload_q[i];
            end else if (en_q[i] && tick_q) begin
                if (mode_q[i] == MODE_UP) begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                    set[i]   = &cnt_q[i];
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end else begin
                    set[i] = 1'b1;
                    if (mode_q[i] == MODE_PER) cnt_d[i] = reload_q[i];
                    else                       en_d[i]  = 1'b0;
                end
            end

            // Software write overrides the one-shot auto-disable.
            if (load_d[i]) begin
                nv_cfg      = (img & ~bm) | (reg_wdata & bm);
                reload_d[i] = nv_cfg[TMR_W-1:0];
                en_d[i]     = nv_cfg[24];
                mode_d[i]   = nv_cfg[26:25];
            end
        end

        stat_d  = (stat_q & ~clr) | set;
        evt_d   = set;
        irq_d   = |(stat_q & mask_q);
        ack_d   = acc;
        rdata_d = acc ? rd_mux : rdata_q;
    end

    assign unused_bits = ^{nv_cfg, nv_glbl, nv_mask, nv_clr};

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            div_q   <= '0;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            stat_q  <= '0;
            mask_q  <= '0;
            evt_q   <= '0;
            en_q    <= '0;
            load_q  <= '0;
            irq_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < NUM_TMR; i++) begin
                reload_q[i] <= '0;
                cnt_q[i]    <= '0;
                mode_q[i]   <= '0;
            end
        end else begin
            div_q   <= div_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            stat_q  <= stat_d;
            mask_q  <= mask_d;
            evt_q   <= evt_d;
            en_q    <= en_d;
            load_q  <= load_d;
            irq_q   <= irq_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            for (int i = 0; i < NUM_TMR; i++) begin
                reload_q[i] <= reload_d[i];
                cnt_q[i]    <= cnt_d[i];
                mode_q[i]   <= mode_d[i];
            end
        end
    end

    assign reg_rdata = rdata_q;
    assign reg_ack   = ack_q;
    assign tmr_tick  = tick_q;
    assign tmr_event = evt_q;
    assign tmr_irq   = irq_q;
endmodule

// File: tb/tb_timer_reg_mc.sv
// tb_timer_reg_mc: directed bench for timer_reg_mc.
// Instance uses TMR_W=4 so the up-counter wrap is reachable.
module tb_timer_reg_mc;
    localparam int N  = 4;
    localparam int TW = 4;
    localparam logic [31:0] EN    = 32'h0100_0000;
    localparam logic [31:0] M_PER = 32'h0200_0000;
    localparam logic [31:0] M_UP  = 32'h0400_0000;

    logic        mclk = 1'b0;
    logic        h_reset_n = 1'b0;
    logic        reg_cs = 1'b0;
    logic        reg_wr = 1'b0;
    logic [3:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [3:0]  reg_be = '0;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        tmr_tick;
    logic [N-1:0] tmr_event;
    logic        tmr_irq;

    int checks = 0;
    int failures = 0;

    timer_reg_mc #(.NUM_TMR(N), .TMR_W(TW), .PRESCALE_W(10), .AW(4)) dut (
        .mclk(mclk), .h_reset_n(h_reset_n),
        .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_be(reg_be),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .tmr_tick(tmr_tick), .tmr_event(tmr_event), .tmr_irq(tmr_irq)
    );

    always #5 mclk = ~mclk;

    // One bus access; returns at posedge+1 of the ack cycle.
    task automatic xfer(input logic w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rd, output int lat);
        if (reg_ack) begin @(posedge mclk); #1; end
        reg_cs = 1'b1; reg_wr = w; reg_addr = a;
        reg_wdata = d; reg_be = be; lat = 0;
        do begin @(posedge mclk); #1; lat++; end
        while (reg_ack !== 1'b1 && lat < 6);
        rd = reg_rdata;
        reg_cs = 1'b0; reg_wr = 1'b0;
        checks++;
        if (reg_ack !== 1'b1) begin
            failures++;
            $display("FAIL bus_timeout addr=%0d no ack after %0d cycles", a, lat);
        end
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] be);
        logic [31:0] rd; int lat;
        xfer(1'b1, a, d, be, rd, lat);
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [31:0] rd);
        int lat;
        xfer(1'b0, a, 32'h0, 4'hF, rd, lat);
    endtask

    task automatic test_reset;
        logic [31:0] rd; int lat;
        h_reset_n = 1'b0;
        #3;
        checks++;
        if ({reg_rdata, reg_ack, tmr_tick, tmr_event, tmr_irq} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {reg_rdata, reg_ack, tmr_tick, tmr_event, tmr_irq});
        end
        @(posedge mclk); #1;
        h_reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            xfer(1'b0, 4'(a), 32'h0, 4'hF, rd, lat);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL reset_read addr=%0d got=%h want=0", a, rd);
            end
            checks++;
            if (lat != 1) begin
                failures++;
                $display("FAIL ack_latency addr=%0d got=%0d want=1", a, lat);
            end
            @(posedge mclk); #1;
            checks++;
            if (reg_ack !== 1'b0) begin
                failures++;
                $display("FAIL ack_width addr=%0d got=%b want=0", a, reg_ack);
            end
        end
    endtask

    task automatic test_periodic;
        logic [31:0] rd;
        int tk[$];
        int ev[$];
        wr_reg(4'd0, 32'd3, 4'hF);
        wr_reg(4'd4, EN | M_PER | 32'd2, 4'hF);
        for (int i = 0; i < 60; i++) begin
            @(posedge mclk); #1;
            if (tmr_tick) tk.push_back(i);
            if (tmr_event[0]) ev.push_back(i);
            if (tmr_event[N-1:1] != '0) ev.push_back(-100);
        end
        checks++;
        if (tk.size() < 3 || tk[1] - tk[0] != 4 || tk[2] - tk[1] != 4) begin
            failures++;
            $display("FAIL tick_period n=%0d got=%p want=4 apart", tk.size(), tk);
        end
        checks++;
        if (ev.size() < 3 || ev[1] - ev[0] != 12 || ev[2] - ev[1] != 12) begin
            failures++;
            $display("FAIL event_period n=%0d got=%p want=12 apart", ev.size(), ev);
        end
        rd_reg(4'd1, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("FAIL periodic_stat got=%h want=1", rd);
        end
        wr_reg(4'd4, 32'h0, 4'hF);
        wr_reg(4'd0, 32'h0, 4'hF);
        wr_reg(4'd1, 32'hF, 4'hF);
        rd_reg(4'd1, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL stat_clear got=%h want=0", rd);
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] rd;
        int n = 0;
        int first = -1;
        wr_reg(4'd4, EN | 32'd5, 4'hF);
        for (int i = 1; i <= 40; i++) begin
            @(posedge mclk); #1;
            if (tmr_event[0]) begin
                n++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (n != 1 || first != 7) begin
            failures++;
            $display("FAIL oneshot_event count=%0d at=%0d want 1 at 7", n, first);
        end
        rd_reg(4'd4, rd);
        checks++;
        if (rd !== 32'h5) begin
            failures++;
            $display("FAIL oneshot_cfg got=%h want=5", rd);
        end
        rd_reg(4'd5, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL oneshot_cnt got=%h want=0", rd);
        end
        wr_reg(4'd1, 32'hF, 4'hF);
    endtask

    task automatic test_up;
        logic [31:0] r1, r2;
        int e0 = -1;
        int e1 = -1;
        wr_reg(4'd8, EN | M_UP, 4'hF);
        for (int i = 1; i <= 40; i++) begin
            @(posedge mclk); #1;
            if (tmr_event[2]) begin
                if (e0 < 0) e0 = i;
                else if (e1 < 0) e1 = i;
            end
        end
        checks++;
        if (e0 != 17 || e1 != 33) begin
            failures++;
            $display("FAIL up_wrap got=%0d,%0d want=17,33", e0, e1);
        end
        rd_reg(4'd9, r1);
        rd_reg(4'd9, r2);
        checks++;
        if (((r2 - r1) & 32'hF) != 32'd2 || r2[31:4] != 0) begin
            failures++;
            $display("FAIL up_count got=%h,%h want step 2", r1, r2);
        end
        rd_reg(4'd1, r1);
        checks++;
        if (r1 !== 32'h4) begin
            failures++;
            $display("FAIL up_stat got=%h want=4", r1);
        end
        wr_reg(4'd8, 32'h0, 4'hF);
        wr_reg(4'd1, 32'hF, 4'hF);
    endtask

    task automatic test_irq;
        logic [31:0] rd;
        logic [N-1:0] ev2;
        logic irq2, irq3;
        wr_reg(4'd2, 32'h2, 4'hF);
        wr_reg(4'd6, EN, 4'hF);
        @(posedge mclk); #1;
        @(posedge mclk); #1;
        ev2 = tmr_event; irq2 = tmr_irq;
        @(posedge mclk); #1;
        irq3 = tmr_irq;
        checks++;
        if (ev2 !== 4'b0010 || irq2 !== 1'b0 || irq3 !== 1'b1) begin
            failures++;
            $display("FAIL irq_timing got ev=%b irq=%b,%b want 0010 0,1",
                     ev2, irq2, irq3);
        end
        wr_reg(4'd1, 32'h2, 4'h0);
        rd_reg(4'd1, rd);
        checks++;
        if (rd !== 32'h2 || tmr_irq !== 1'b1) begin
            failures++;
            $display("FAIL w1c_be0 got=%h irq=%b want=2 1", rd, tmr_irq);
        end
        wr_reg(4'd1, 32'h2, 4'h1);
        irq2 = tmr_irq;
        @(posedge mclk); #1;
        checks++;
        if (irq2 !== 1'b1 || tmr_irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_fall got=%b,%b want=1,0", irq2, tmr_irq);
        end
        rd_reg(4'd1, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL w1c_clear got=%h want=0", rd);
        end
        wr_reg(4'd6, EN | M_PER, 4'hF);
        wr_reg(4'd1, 32'h2, 4'hF);
        rd_reg(4'd1, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("FAIL set_wins got=%h want=2", rd);
        end
        wr_reg(4'd6, 32'h0, 4'hF);
        wr_reg(4'd1, 32'h2, 4'hF);
        rd_reg(4'd1, rd);
        checks++;
        if (rd !== 32'h0 || tmr_irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_idle got=%h irq=%b want=0 0", rd, tmr_irq);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r1;
        logic a1, a2, a3;
        wr_reg(4'd0, 32'd7, 4'hF);
        if (reg_ack) begin @(posedge mclk); #1; end
        reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = 4'd2;
        @(posedge mclk); #1;
        a1 = reg_ack; r1 = reg_rdata; reg_addr = 4'd0;
        @(posedge mclk); #1;
        a2 = reg_ack;
        @(posedge mclk); #1;
        a3 = reg_ack;
        reg_cs = 1'b0;
        checks++;
        if ({a1, a2, a3} !== 3'b101) begin
            failures++;
            $display("FAIL b2b_ack got=%b want=101", {a1, a2, a3});
        end
        checks++;
        if (r1 !== 32'h2 || reg_rdata !== 32'h7) begin
            failures++;
            $display("FAIL b2b_data got=%h,%h want=2,7", r1, reg_rdata);
        end
        wr_reg(4'd0, 32'h0, 4'hF);
    endtask

    task automatic test_wmask;
        logic [31:0] rd;
        wr_reg(4'd10, 32'h0300_0009, 4'h1);
        rd_reg(4'd10, rd);
        checks++;
        if (rd !== 32'h9) begin
            failures++;
            $display("FAIL cfg_be got=%h want=9", rd);
        end
        wr_reg(4'd11, 32'h0, 4'hF);
        rd_reg(4'd11, rd);
        checks++;
        if (rd !== 32'h9) begin
            failures++;
            $display("FAIL cnt_ro got=%h want=9", rd);
        end
        wr_reg(4'd3, 32'hFFFF_FFFF, 4'hF);
        rd_reg(4'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL reserved got=%h want=0", rd);
        end
        wr_reg(4'd0, 32'h0000_0305, 4'h2);
        rd_reg(4'd0, rd);
        checks++;
        if (rd !== 32'h300) begin
            failures++;
            $display("FAIL glbl_be got=%h want=300", rd);
        end
        wr_reg(4'd0, 32'h0, 4'hF);
        wr_reg(4'd10, 32'h0, 4'hF);
    endtask

    task automatic test_async_reset;
        logic [31:0] rd;
        int n = 0;
        wr_reg(4'd2, 32'h1, 4'hF);
        wr_reg(4'd4, EN | M_PER | 32'd1, 4'hF);
        repeat (6) begin @(posedge mclk); #1; end
        checks++;
        if (tmr_irq !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_irq got=%b want=1", tmr_irq);
        end
        if (reg_ack) begin @(posedge mclk); #1; end
        reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = 4'd5;
        #2 h_reset_n = 1'b0;
        #1;
        checks++;
        if ({reg_rdata, reg_ack, tmr_tick, tmr_event, tmr_irq} !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0",
                     {reg_rdata, reg_ack, tmr_tick, tmr_event, tmr_irq});
        end
        @(posedge mclk); #1;
        checks++;
        if (reg_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_ack got=%b want=0", reg_ack);
        end
        reg_cs = 1'b0;
        #2 h_reset_n = 1'b1;
        @(posedge mclk); #1;
        for (int i = 0; i < 20; i++) begin
            @(posedge mclk); #1;
            if (tmr_event != '0) n++;
        end
        rd_reg(4'd4, rd);
        checks++;
        if (n != 0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_idle events=%0d cfg=%h want 0 0", n, rd);
        end
        n = 0;
        wr_reg(4'd4, EN | M_PER | 32'd1, 4'hF);
        for (int i = 1; i <= 20; i++) begin
            @(posedge mclk); #1;
            if (tmr_event[0]) n++;
        end
        checks++;
        if (n != 9) begin
            failures++;
            $display("FAIL resume_events got=%0d want=9", n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_up();
        test_irq();
        test_back_to_back();
        test_wmask();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
